// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath shift unit.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    // Direction encodings on Control
    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/alu_shifter_if.sv
// Operand/result bundle between the datapath and the shift unit.
interface alu_shifter_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
);

    logic             Control;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] Answer;

    modport master (
        output Control,
        output A,
        input  Answer
    );

    modport slave (
        input  Control,
        input  A,
        output Answer
    );

endinterface

// File: rtl/alu_shifter_shift_core.sv
// Combinational single-direction logical shift; produces the next Answer.
module shift_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned SHIFT_AMT = 1
) (
    input  logic             Control,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] result
);

    // Only an explicit right encoding shifts right; anything else, X included, shifts left
    always_comb begin
        result = '0;
        if (Control == SHIFT_RIGHT) begin
            result = A >> SHIFT_AMT;
        end else begin
            result = A << SHIFT_AMT;
        end
    end

endmodule

// File: rtl/alu_shifter.sv
// Registered 16-bit logical shifter: one-cycle latency, async active-low clear.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned SHIFT_AMT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_shifter_if.slave  bus
);

    logic [WIDTH-1:0] next_answer;

    shift_core #(
        .WIDTH     (WIDTH),
        .SHIFT_AMT (SHIFT_AMT)
    ) u_shift_core (
        .Control (bus.Control),
        .A       (bus.A),
        .result  (next_answer)
    );

    // Output register: cleared immediately on reset, reloaded every edge otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Answer <= '0;
        end else begin
            bus.Answer <= next_answer;
        end
    end

endmodule

// File: tb/tb_alu_shifter.sv
// Self-checking bench for alu_shifter: vector table plus reset/latency sequences.
module tb_alu_shifter;

    logic clk;
    logic rst_n;

    alu_shifter_if #(.WIDTH(16)) bus ();

    alu_shifter #(
        .WIDTH     (16),
        .SHIFT_AMT (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [15:0] a;
        logic        ctrl;
        logic [15:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive operands away from the edge, queue the expected result, compare after the edge
    task automatic apply(input string name, input logic [15:0] a, input logic ctrl, input logic [15:0] exp);
        logic [15:0] e;
        @(negedge clk);
        bus.A = a;
        bus.Control = ctrl;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %h expected queued value", name, bus.Answer);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.Answer, e);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic [15:0] ra;
        logic        rc;

        vecs.push_back('{"msb_lsb_left",  16'h8001, 1'b0, 16'h0002});
        vecs.push_back('{"msb_lsb_right", 16'h8001, 1'b1, 16'h4000});
        vecs.push_back('{"ones_left",     16'hFFFF, 1'b0, 16'hFFFE});
        vecs.push_back('{"ones_right",    16'hFFFF, 1'b1, 16'h7FFF});
        vecs.push_back('{"zero_left",     16'h0000, 1'b0, 16'h0000});
        vecs.push_back('{"zero_right",    16'h0000, 1'b1, 16'h0000});
        vecs.push_back('{"pattern_left",  16'hA5A5, 1'b0, 16'h4B4A});
        vecs.push_back('{"pattern_right", 16'hA5A5, 1'b1, 16'h52D2});
        vecs.push_back('{"lsb_right",     16'h0001, 1'b1, 16'h0000});
        vecs.push_back('{"msb_left",      16'h8000, 1'b0, 16'h0000});

        // Load a nonzero value, then clear asynchronously between edges
        rst_n = 1'b1;
        bus.A = 16'h1234;
        bus.Control = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_load", bus.Answer, 16'h2468);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", bus.Answer, 16'h0000);
        bus.A = 16'hFFFF;
        bus.Control = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_hold", bus.Answer, 16'h0000);
        end

        // Release and first capture
        @(negedge clk);
        rst_n = 1'b1;
        apply("first_left", 16'd10, 1'b0, 16'd20);

        // Latency: old result must persist until the next edge
        @(negedge clk);
        bus.A = 16'd9;
        bus.Control = 1'b1;
        exp_q.push_back(16'd4);
        #1;
        check("hold_before_edge", bus.Answer, 16'd20);
        @(posedge clk);
        #1;
        check("right_9", bus.Answer, exp_q.pop_front());

        // Mid-cycle input glitch must not reach Answer
        @(negedge clk);
        bus.A = 16'h00F0;
        bus.Control = 1'b0;
        #2;
        check("glitch_no_effect", bus.Answer, 16'd4);
        bus.A = 16'h0100;
        bus.Control = 1'b1;
        exp_q.push_back(16'h0080);
        @(posedge clk);
        #1;
        check("after_glitch", bus.Answer, exp_q.pop_front());

        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].a, vecs[i].ctrl, vecs[i].exp);
        end

        // Random operands against an independent bit-concatenation model
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            apply("random", ra, rc, rc ? {1'b0, ra[15:1]} : {ra[14:0], 1'b0});
        end

        // Reset pulse mid-operation
        apply("set_fffe", 16'hFFFF, 1'b0, 16'hFFFE);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset", bus.Answer, 16'h0000);
        #1;
        rst_n = 1'b1;
        bus.A = 16'd3;
        bus.Control = 1'b0;
        #1;
        check("released_before_edge", bus.Answer, 16'h0000);
        exp_q.push_back(16'd6);
        @(posedge clk);
        #1;
        check("resume_after_reset", bus.Answer, exp_q.pop_front());

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
